// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared opcode constants, the canonical NOP word and the
//               IF/ID pipeline latch record used by the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_target;
  } if_id_t;

  // Contents of the IF/ID latch after reset and whenever a bubble is inserted.
  localparam if_id_t IF_ID_BUBBLE = '{
    valid:       1'b0,
    pc:          32'h0,
    instr:       NOP_INSTR,
    pred_taken:  1'b0,
    pred_target: 32'h0
  };

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/static_bp_adder.sv
`default_nettype none
// ============================================================================
// Module      : static_bp_adder
// Description : Plain combinational adder, wraps modulo 2^W, no carry out.
// Ports       : a_i, b_i  - operands
//               sum_o     - a_i + b_i (truncated to W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module static_bp_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule : static_bp_adder
`default_nettype wire

// File: rtl/static_bp_decode.sv
`default_nettype none
// ============================================================================
// Module      : static_bp_decode
// Description : Combinational immediate extraction and static direction
//               prediction. B-type: backward taken / forward not taken.
//               JAL: always taken. Everything else (incl. JALR): not taken,
//               immediate zero.
// Ports       : instr_i      - fetched instruction word
//               imm_o        - sign-extended branch/jump offset
//               pred_taken_o - static prediction
// Revision    : 1.0 - initial release
// ============================================================================
module static_bp_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output logic        pred_taken_o
);

  logic [6:0] opcode;
  assign opcode = instr_i[6:0];

  always_comb begin
    imm_o        = 32'h0;
    pred_taken_o = 1'b0;
    case (opcode)
      OPC_BRANCH: begin
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                 instr_i[30:25], instr_i[11:8], 1'b0};
        // Sign bit of the offset: negative offset means a backward branch.
        pred_taken_o = instr_i[31];
      end
      OPC_JAL: begin
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                 instr_i[20], instr_i[30:21], 1'b0};
        pred_taken_o = 1'b1;
      end
      // Register-indirect target is unknown at fetch.
      OPC_JALR: begin
        imm_o        = 32'h0;
        pred_taken_o = 1'b0;
      end
      default: begin
        imm_o        = 32'h0;
        pred_taken_o = 1'b0;
      end
    endcase
  end

endmodule : static_bp_decode
`default_nettype wire

// File: rtl/static_bp_fetch.sv
`default_nettype none
// ============================================================================
// Module      : static_bp_fetch
// Description : Fetch stage with static branch prediction. Owns the PC,
//               drives PC+4 / PC+imm adders, registers the IF/ID latch,
//               accepts EX redirects and keeps saturating branch statistics.
// Ports       : clk, reset (async, active-high)
//               imem_instr / imem_addr        - combinational IMEM interface
//               id_stall                      - hold PC and IF/ID
//               ex_redirect / ex_redirect_pc  - mispredict recovery
//               ex_branch_resolved / ex_mispredict - statistics inputs
//               if_id_*                       - IF/ID latch outputs
//               branch_cnt / mispred_cnt      - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module static_bp_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      imem_addr,
  input  logic             id_stall,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  input  logic             ex_branch_resolved,
  input  logic             ex_mispredict,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_pred_taken,
  output logic [31:0]      if_id_pred_target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [31:0]      pc_q, pc_d;
  if_id_t           if_id_q, if_id_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [31:0] imm;
  logic        pred_taken;
  logic [31:0] seq_pc;
  logic [31:0] tgt_pc;

  static_bp_decode u_decode (
    .instr_i      (imem_instr),
    .imm_o        (imm),
    .pred_taken_o (pred_taken)
  );

  static_bp_adder #(.W(32)) u_add_seq (
    .a_i   (pc_q),
    .b_i   (32'd4),
    .sum_o (seq_pc)
  );

  static_bp_adder #(.W(32)) u_add_tgt (
    .a_i   (pc_q),
    .b_i   (imm),
    .sum_o (tgt_pc)
  );

  // Next-PC / IF/ID selection. A redirect wins over a stall so the
  // wrong-path word fetched this cycle is dropped as a single bubble.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    if (ex_redirect) begin
      pc_d    = ex_redirect_pc;
      if_id_d = IF_ID_BUBBLE;
    end else if (!id_stall) begin
      pc_d                = pred_taken ? tgt_pc : seq_pc;
      if_id_d.valid       = 1'b1;
      if_id_d.pc          = pc_q;
      if_id_d.instr       = imem_instr;
      if_id_d.pred_taken  = pred_taken;
      if_id_d.pred_target = tgt_pc;
    end
  end

  // Statistics saturate at all-ones; a mispredict without a resolved
  // branch carries no meaning and is ignored.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_branch_resolved && (branch_cnt_q != {CNT_W{1'b1}}))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (ex_branch_resolved && ex_mispredict && (mispred_cnt_q != {CNT_W{1'b1}}))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      if_id_q       <= IF_ID_BUBBLE;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign imem_addr         = pc_q;
  assign if_id_valid       = if_id_q.valid;
  assign if_id_pc          = if_id_q.pc;
  assign if_id_instr       = if_id_q.instr;
  assign if_id_pred_taken  = if_id_q.pred_taken;
  assign if_id_pred_target = if_id_q.pred_target;
  assign branch_cnt        = branch_cnt_q;
  assign mispred_cnt       = mispred_cnt_q;

endmodule : static_bp_fetch
`default_nettype wire

// File: tb/tb_static_bp_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_static_bp_fetch
// Description : Scoreboard bench for static_bp_fetch. The driver applies one
//               vector per cycle on the falling edge and queues the state
//               expected after the next rising edge; the monitor pops and
//               compares just after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_static_bp_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BNEG = 32'hFE00_0CE3; // beq -8
  localparam logic [31:0] BPOS = 32'h0000_0863; // beq +16
  localparam logic [31:0] JAL  = 32'h0400_006F; // jal +0x40
  localparam logic [31:0] JALR = 32'h0000_8067; // jalr x0,0(x1)

  // Check modes: full IF/ID, bubble (pc/valid/instr), counters only.
  localparam int M_FULL = 0;
  localparam int M_BUB  = 1;
  localparam int M_CNT  = 2;

  typedef struct {
    int          mode;
    logic [31:0] pc;
    logic        v;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        pt;
    logic [31:0] tgt;
    logic [3:0]  bc;
    logic [3:0]  mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_branch_resolved;
  logic        ex_mispredict;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  static_bp_fetch #(.RESET_VECTOR(32'h100), .CNT_W(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_instr         (imem_instr),
    .imem_addr          (imem_addr),
    .id_stall           (id_stall),
    .ex_redirect        (ex_redirect),
    .ex_redirect_pc     (ex_redirect_pc),
    .ex_branch_resolved (ex_branch_resolved),
    .ex_mispredict      (ex_mispredict),
    .if_id_valid        (if_id_valid),
    .if_id_pc           (if_id_pc),
    .if_id_instr        (if_id_instr),
    .if_id_pred_taken   (if_id_pred_taken),
    .if_id_pred_target  (if_id_pred_target),
    .branch_cnt         (branch_cnt),
    .mispred_cnt        (mispred_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int mode, input logic [31:0] pc, input logic v,
                              input logic [31:0] ifpc, input logic [31:0] instr,
                              input logic pt, input logic [31:0] tgt,
                              input logic [3:0] bc, input logic [3:0] mc);
    exp_t e;
    e.mode = mode; e.pc = pc; e.v = v; e.ifpc = ifpc; e.instr = instr;
    e.pt = pt; e.tgt = tgt; e.bc = bc; e.mc = mc;
    return e;
  endfunction

  // Apply one vector (caller sits on a falling edge) and queue its expectation.
  task automatic step(input logic [31:0] instr, input logic stall, input logic redir,
                      input logic [31:0] rpc, input logic br, input logic mp, input exp_t e);
    imem_instr         = instr;
    id_stall           = stall;
    ex_redirect        = redir;
    ex_redirect_pc     = rpc;
    ex_branch_resolved = br;
    ex_mispredict      = mp;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("branch_cnt", 32'(branch_cnt), 32'(e.bc));
      chk("mispred_cnt", 32'(mispred_cnt), 32'(e.mc));
      if (e.mode != M_CNT) begin
        chk("imem_addr", imem_addr, e.pc);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.v));
        chk("if_id_instr", if_id_instr, e.instr);
      end
      if (e.mode == M_FULL) begin
        chk("if_id_pc", if_id_pc, e.ifpc);
        chk("if_id_pred_taken", 32'(if_id_pred_taken), 32'(e.pt));
        chk("if_id_pred_target", if_id_pred_target, e.tgt);
      end
    end
  end

  // Counter phase table: br, mp, expected branch_cnt, expected mispred_cnt.
  logic       t_br [25] = '{1,1,0,1,1,1,0,1,1,1,1,1, 1,1,1,1,1,1, 1,1,1,1,1,1,1};
  logic       t_mp [25] = '{0,1,1,0,1,0,1,0,1,0,0,0, 1,1,1,1,1,1, 1,1,1,1,1,1,1};
  logic [3:0] t_bc [25] = '{1,2,2,3,4,5,5,6,7,8,9,10, 11,12,13,14,15,15, 15,15,15,15,15,15,15};
  logic [3:0] t_mc [25] = '{0,1,1,1,2,2,2,2,3,3,3,3, 4,5,6,7,8,9, 10,11,12,13,14,15,15};

  initial begin
    reset = 1'b1; imem_instr = NOP; id_stall = 1'b0; ex_redirect = 1'b0;
    ex_redirect_pc = 32'h0; ex_branch_resolved = 1'b0; ex_mispredict = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst imem_addr", imem_addr, 32'h100);
    chk("rst if_id_valid", 32'(if_id_valid), 32'h0);
    chk("rst if_id_instr", if_id_instr, NOP);
    chk("rst if_id_pc", if_id_pc, 32'h0);
    chk("rst pred_taken", 32'(if_id_pred_taken), 32'h0);
    chk("rst pred_target", if_id_pred_target, 32'h0);
    chk("rst branch_cnt", 32'(branch_cnt), 32'h0);
    reset = 1'b0;

    // Sequential NOP fetch from the reset vector
    step(NOP, 0, 0, 0, 0, 0, mk(M_FULL, 32'h104, 1, 32'h100, NOP, 0, 32'h100, 0, 0));
    step(NOP, 0, 0, 0, 0, 0, mk(M_FULL, 32'h108, 1, 32'h104, NOP, 0, 32'h104, 0, 0));
    step(NOP, 0, 0, 0, 0, 0, mk(M_FULL, 32'h10C, 1, 32'h108, NOP, 0, 32'h108, 0, 0));
    // Backward branch, taken
    step(NOP,  0, 1, 32'h200, 0, 0, mk(M_BUB, 32'h200, 0, 0, NOP, 0, 0, 0, 0));
    step(BNEG, 0, 0, 0, 0, 0, mk(M_FULL, 32'h1F8, 1, 32'h200, BNEG, 1, 32'h1F8, 0, 0));
    step(NOP,  0, 0, 0, 0, 0, mk(M_FULL, 32'h1FC, 1, 32'h1F8, NOP, 0, 32'h1F8, 0, 0));
    // Forward branch, not taken
    step(NOP,  0, 1, 32'h200, 0, 0, mk(M_BUB, 32'h200, 0, 0, NOP, 0, 0, 0, 0));
    step(BPOS, 0, 0, 0, 0, 0, mk(M_FULL, 32'h204, 1, 32'h200, BPOS, 0, 32'h210, 0, 0));
    // JAL taken, JALR not predicted
    step(NOP,  0, 1, 32'h300, 0, 0, mk(M_BUB, 32'h300, 0, 0, NOP, 0, 0, 0, 0));
    step(JAL,  0, 0, 0, 0, 0, mk(M_FULL, 32'h340, 1, 32'h300, JAL, 1, 32'h340, 0, 0));
    step(JALR, 0, 0, 0, 0, 0, mk(M_FULL, 32'h344, 1, 32'h340, JALR, 0, 32'h340, 0, 0));
    // Three-cycle stall, a taken JAL on the bus must be ignored
    for (int i = 0; i < 3; i++)
      step(JAL, 1, 0, 0, 0, 0, mk(M_FULL, 32'h344, 1, 32'h340, JALR, 0, 32'h340, 0, 0));
    step(NOP,  0, 0, 0, 0, 0, mk(M_FULL, 32'h348, 1, 32'h344, NOP, 0, 32'h344, 0, 0));
    // Redirect overrides stall
    step(JAL,  1, 1, 32'h500, 0, 0, mk(M_BUB, 32'h500, 0, 0, NOP, 0, 0, 0, 0));
    step(NOP,  0, 0, 0, 0, 0, mk(M_FULL, 32'h504, 1, 32'h500, NOP, 0, 32'h500, 0, 0));
    // PC wrap
    step(NOP,  0, 1, 32'hFFFF_FFFC, 0, 0, mk(M_BUB, 32'hFFFF_FFFC, 0, 0, NOP, 0, 0, 0, 0));
    step(NOP,  0, 0, 0, 0, 0, mk(M_FULL, 32'h0, 1, 32'hFFFF_FFFC, NOP, 0, 32'hFFFF_FFFC, 0, 0));

    // Counters, with a stall and a redirect mixed in
    for (int i = 0; i < 25; i++)
      step(NOP, (i == 3), (i == 5), 32'h0, t_br[i], t_mp[i],
           mk(M_CNT, 0, 0, 0, 0, 0, 0, t_bc[i], t_mc[i]));

    // Asynchronous reset between clock edges
    ex_branch_resolved = 1'b0; ex_mispredict = 1'b0; ex_redirect = 1'b0; id_stall = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async branch_cnt", 32'(branch_cnt), 32'h0);
    chk("async mispred_cnt", 32'(mispred_cnt), 32'h0);
    chk("async imem_addr", imem_addr, 32'h100);
    chk("async if_id_valid", 32'(if_id_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(NOP, 0, 0, 0, 0, 0, mk(M_FULL, 32'h104, 1, 32'h100, NOP, 0, 32'h100, 0, 0));

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_static_bp_fetch
`default_nettype wire
